// File: rtl/fifo_access_scheduler.sv
// Arbitrates NUM_REQ write requesters and one reader onto a single-port FIFO.
// Reads and writes alternate when both are pending; writers are served round-robin.
module fifo_access_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          rd_req,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          fifo_rd_en,
  output logic                          rd_data_valid,
  output logic [GW-1:0]                 grant_id,
  output logic [CW-1:0]                 count,
  output logic                          full,
  output logic                          empty
);

  typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} op_e;

  logic [CW-1:0] count_q, count_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] grant_q, grant_d;
  op_e           last_op_q, last_op_d;
  logic          rd_vld_q;

  logic          rd_cand, wr_cand, issue_wr, issue_rd;
  logic          win_found;
  logic [GW-1:0] win_idx, cand_idx;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  assign rd_cand = rd_req && !empty;
  assign wr_cand = (|req_valid) && !full;

  // Gating with reset_n keeps strobes quiet while reset is held.
  assign issue_wr = reset_n && wr_cand && (!rd_cand || last_op_q == OP_RD);
  assign issue_rd = reset_n && rd_cand && (!wr_cand || last_op_q == OP_WR);

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx = GW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!win_found && req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    req_ready    = '0;
    fifo_wr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (issue_wr && win_found && win_idx == GW'(i)) begin
        req_ready[i] = 1'b1;
        fifo_wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign fifo_wr_en = |(req_valid & req_ready);
  assign fifo_rd_en = issue_rd;

  always_comb begin
    count_d   = count_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    last_op_d = last_op_q;
    if (fifo_wr_en) begin
      count_d   = count_q + CW'(1);
      rr_ptr_d  = win_idx;
      grant_d   = win_idx;
      last_op_d = OP_WR;
    end else if (fifo_rd_en) begin
      count_d   = count_q - CW'(1);
      last_op_d = OP_RD;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      rr_ptr_q  <= GW'(NUM_REQ - 1);
      grant_q   <= '0;
      last_op_q <= OP_RD;
      rd_vld_q  <= 1'b0;
    end else begin
      count_q   <= count_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      last_op_q <= last_op_d;
      rd_vld_q  <= fifo_rd_en;
    end
  end

  assign grant_id      = grant_q;
  assign count         = count_q;
  assign rd_data_valid = rd_vld_q;

endmodule
